muldiv_seq: RTL

Iterative multiply/divide sequencer that owns the HI/LO register pair next to the ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from the main decoder and runs one shared 32-step shift-add/shift-subtract datapath. It exposes `busy`/`done`/`stall` so control can freeze the pipeline, and it drives HI/LO to the writeback mux for MFHI/MFLO.

---
 rtl/muldiv_seq.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer that owns the HI/LO register pair.
// One shared radix-2 datapath, 32 steps per operation, plus a one-cycle sign fix-up.
// Build option MULDIV_DIV_EN: when defined, the restoring divider and the sticky dz
// flag are compiled in. When undefined, DIV/DIVU are no-ops and dz is tied low.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic             dz
);

  localparam int               CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic               neg_q;
  logic [2*WIDTH-1:0] acc_p0, acc_step, res;
  logic [WIDTH-1:0]   opd_p0;
  logic [WIDTH:0]     sum_p0;
  logic               op_md, op_div, op_signed, a_neg, b_neg, accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
`ifdef MULDIV_DIV_EN
  logic               is_div, neg_r, div0, div0_in;
  logic [WIDTH:0]     trial_p0;
`endif

  // Two's-complement negate of a single-width value.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    logic signed [WIDTH-1:0] s;
    s = x;
    return -s;
  endfunction

  // Two's-complement negate of the double-width product.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    logic signed [2*WIDTH-1:0] s;
    s = x;
    return -s;
  endfunction

  // Decode the request and form operand magnitudes for the signed ops.
  always_comb begin
    op_signed = ~op[0];
    op_div    = 1'b0;
`ifdef MULDIV_DIV_EN
    op_div    = (op[2:1] == 2'b01);
    div0_in   = op_div & (b == '0);
`endif
    op_md     = (op[2:1] == 2'b00) | op_div;
    a_neg     = op_signed & a[WIDTH-1];
    b_neg     = op_signed & b[WIDTH-1];
    a_mag     = a_neg ? neg_w(a) : a;
    b_mag     = b_neg ? neg_w(b) : b;
    accept    = start & (state == IDLE) & op_md;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: a divide by zero skips the iterations and goes straight to fix-up.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = CALC;
`ifdef MULDIV_DIV_EN
          if (div0_in) state_nxt = FIX;
`endif
        end
      end
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy covers CALC and FIX, so a request in FIX is stalled too.
  always_comb begin
    busy  = (state != IDLE);
    stall = start & busy;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    sum_p0   = {1'b0, acc_p0[2*WIDTH-1:WIDTH]} + {1'b0, opd_p0};
    acc_step = acc_p0[0] ? {sum_p0, acc_p0[WIDTH-1:1]} : {1'b0, acc_p0[2*WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    trial_p0 = acc_p0[2*WIDTH-1:WIDTH-1] - {1'b0, opd_p0};
    if (is_div)
      acc_step = trial_p0[WIDTH] ? {acc_p0[2*WIDTH-2:0], 1'b0}
                                 : {trial_p0[WIDTH-1:0], acc_p0[WIDTH-2:0], 1'b1};
`endif
  end

  // Fix-up: restore signs of the magnitude result before it lands in HI/LO.
  always_comb begin
    res = neg_q ? neg_2w(acc_p0) : acc_p0;
`ifdef MULDIV_DIV_EN
    if (div0) begin
      res = acc_p0;
    end else if (is_div) begin
      res[WIDTH-1:0]       = neg_q ? neg_w(acc_p0[WIDTH-1:0]) : acc_p0[WIDTH-1:0];
      res[2*WIDTH-1:WIDTH] = neg_r ? neg_w(acc_p0[2*WIDTH-1:WIDTH])
                                   : acc_p0[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // Stage p0: accumulator and operand register, loaded at accept, stepped in CALC.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_p0 <= {{WIDTH{1'b0}}, b_mag};
      opd_p0 <= a_mag;
`ifdef MULDIV_DIV_EN
      if (op_div) begin
        acc_p0 <= {{WIDTH{1'b0}}, a_mag};
        opd_p0 <= b_mag;
      end
      if (div0_in) acc_p0 <= {a, {WIDTH{1'b1}}};
`endif
    end else if (state == CALC) begin
      acc_p0 <= acc_step;
    end
  end

  // Control, counter and HI/LO: results land only in FIX or on MTHI/MTLO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      neg_q <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef MULDIV_DIV_EN
      is_div <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      dz     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        cnt   <= '0;
        neg_q <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
        is_div <= op_div;
        neg_r  <= a_neg;
        div0   <= div0_in;
        dz     <= 1'b0;
`endif
      end else if (state == CALC) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state == FIX) begin
        hi   <= res[2*WIDTH-1:WIDTH];
        lo   <= res[WIDTH-1:0];
        done <= 1'b1;
`ifdef MULDIV_DIV_EN
        if (div0) dz <= 1'b1;
`endif
      end else if (start && (state == IDLE) && (op == 3'b100)) begin
        hi <= a;
      end else if (start && (state == IDLE) && (op == 3'b101)) begin
        lo <= a;
      end
    end
  end

`ifndef MULDIV_DIV_EN
  assign dz = 1'b0;
`endif

endmodule
